// File: rtl/frac_clk_divider_if.sv
// rtl/frac_clk_divider_if.sv - configuration handshake bundle for the fractional clock divider
//
// Signals:
//   cfg_valid  master -> slave  a new increment/modulus pair is offered
//   cfg_inc    master -> slave  offered increment (ACC_W bits)
//   cfg_mod    master -> slave  offered modulus (ACC_W bits)
//   cfg_ready  slave -> master  no configuration is pending, an offer will be taken
//   cfg_err    slave -> master  one-cycle pulse when a taken offer is rejected
interface frac_clk_divider_if #(
    parameter int ACC_W = 16
);
    logic             cfg_valid;
    logic [ACC_W-1:0] cfg_inc;
    logic [ACC_W-1:0] cfg_mod;
    logic             cfg_ready;
    logic             cfg_err;

    modport master (
        output cfg_valid, cfg_inc, cfg_mod,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_inc, cfg_mod,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/frac_clk_divider.sv
// rtl/frac_clk_divider.sv - fractional-N clock divider, f_out = f_clk * inc / mod
//
// Ports:
//   clk_100MHz  in   single clock, all state on its rising edge
//   reset_n     in   asynchronous active-low reset
//   en          in   run enable; low clears the accumulator and parks clk_out at 0
//   cfg         if   slave side of the configuration handshake
//   clk_out     out  registered divided clock
//   clk_en      out  one-cycle pulse in the first cycle clk_out reads 1
module frac_clk_divider #(
    parameter int ACC_W   = 16,
    parameter int DEF_INC = 1007,
    parameter int DEF_MOD = 4000
) (
    input  logic               clk_100MHz,
    input  logic               reset_n,
    input  logic               en,
    frac_clk_divider_if.slave  cfg,
    output logic               clk_out,
    output logic               clk_en
);

    if (DEF_INC <= 0 || 2 * DEF_INC > DEF_MOD || (ACC_W < 31 && DEF_MOD >= (1 << ACC_W)))
    begin : g_bad_defaults
        $error("frac_clk_divider: default increment/modulus out of range");
    end

    localparam logic [ACC_W-1:0] DEF_INC_V = DEF_INC[ACC_W-1:0];
    localparam logic [ACC_W-1:0] DEF_MOD_V = DEF_MOD[ACC_W-1:0];

    // acc stays below mod and 2*inc <= mod, so acc + 2*inc < 2*mod fits in ACC_W+1 bits.
    logic [ACC_W:0]   acc_q, acc_d;
    logic [ACC_W-1:0] inc_q, inc_d;
    logic [ACC_W-1:0] mod_q, mod_d;
    logic [ACC_W-1:0] pend_inc_q, pend_inc_d;
    logic [ACC_W-1:0] pend_mod_q, pend_mod_d;
    logic             pend_q, pend_d;
    logic             clk_out_q, clk_out_d;
    logic             clk_en_q, clk_en_d;
    logic             cfg_err_q, cfg_err_d;

    logic [ACC_W:0]   sum;
    logic [ACC_W:0]   sum_wrap;
    logic             tick;
    logic             rise;
    logic             accept;
    logic             cfg_ok;
    logic             apply;

    assign sum      = acc_q + {inc_q, 1'b0};
    assign sum_wrap = sum - {1'b0, mod_q};
    assign tick     = en && (sum >= {1'b0, mod_q});
    assign rise     = tick && !clk_out_q;

    // Only one configuration may be in flight; offers are ignored while one is pending.
    assign accept   = cfg.cfg_valid && !pend_q;
    assign cfg_ok   = (cfg.cfg_inc != '0) && (cfg.cfg_mod != '0) &&
                      ({cfg.cfg_inc, 1'b0} <= {1'b0, cfg.cfg_mod});

    // Switching only at a rising edge of clk_out keeps the old high/low phases intact;
    // with en low the output is already parked at 0 so any edge is safe.
    assign apply    = pend_q && (rise || !en);

    always_comb begin
        acc_d      = acc_q;
        inc_d      = inc_q;
        mod_d      = mod_q;
        pend_inc_d = pend_inc_q;
        pend_mod_d = pend_mod_q;
        pend_d     = pend_q;
        clk_out_d  = clk_out_q;
        clk_en_d   = 1'b0;
        cfg_err_d  = 1'b0;

        if (!en) begin
            acc_d     = '0;
            clk_out_d = 1'b0;
        end else begin
            if (tick) begin
                acc_d     = sum_wrap;
                clk_out_d = !clk_out_q;
            end else begin
                acc_d     = sum;
            end
            clk_en_d = rise;
        end

        if (apply) begin
            inc_d  = pend_inc_q;
            mod_d  = pend_mod_q;
            acc_d  = '0;
            pend_d = 1'b0;
        end

        if (accept) begin
            if (cfg_ok) begin
                pend_d     = 1'b1;
                pend_inc_d = cfg.cfg_inc;
                pend_mod_d = cfg.cfg_mod;
            end else begin
                cfg_err_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            acc_q      <= '0;
            inc_q      <= DEF_INC_V;
            mod_q      <= DEF_MOD_V;
            pend_inc_q <= '0;
            pend_mod_q <= '0;
            pend_q     <= 1'b0;
            clk_out_q  <= 1'b0;
            clk_en_q   <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            inc_q      <= inc_d;
            mod_q      <= mod_d;
            pend_inc_q <= pend_inc_d;
            pend_mod_q <= pend_mod_d;
            pend_q     <= pend_d;
            clk_out_q  <= clk_out_d;
            clk_en_q   <= clk_en_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign clk_out       = clk_out_q;
    assign clk_en        = clk_en_q;
    assign cfg.cfg_ready = !pend_q;
    assign cfg.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_frac_clk_divider.sv
// tb/tb_frac_clk_divider.sv - self-checking bench for frac_clk_divider
module tb_frac_clk_divider;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic en = 1'b0;
    logic clk_out;
    logic clk_en;

    frac_clk_divider_if #(.ACC_W(16)) cfg_bus ();

    frac_clk_divider #(.ACC_W(16), .DEF_INC(1007), .DEF_MOD(4000)) dut (
        .clk_100MHz (clk),
        .reset_n    (reset_n),
        .en         (en),
        .cfg        (cfg_bus),
        .clk_out    (clk_out),
        .clk_en     (clk_en)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Scoreboard: expected clk_out level per sample and expected clk_en sample indices.
    bit exp_lvl[$];
    int exp_rise[$];
    bit exp_prev;
    bit mon_lvl[$];
    bit mon_en[$];
    bit rec = 1'b0;

    // Sample i is the state after the i-th clock edge following start_record.
    always @(negedge clk) begin
        if (rec) begin
            mon_lvl.push_back(clk_out);
            mon_en.push_back(clk_en);
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_record();
        mon_lvl.delete();
        mon_en.delete();
        exp_lvl.delete();
        exp_rise.delete();
        exp_prev = 1'b0;
        rec = 1'b1;
    endtask

    task automatic stop_record();
        @(negedge clk);
        #1;
        rec = 1'b0;
    endtask

    // Ideal behaviour: i edges after a restart at 'origin' there have been floor(2*inc*i/mod) toggles.
    task automatic predict(input int inc, input int mod, input int origin, input bit lvl0,
                           input int from_i, input int to_i);
        longint t;
        bit lvl;
        for (int i = from_i; i <= to_i; i++) begin
            t = (longint'(2 * inc) * longint'(i - origin)) / longint'(mod);
            lvl = lvl0 ^ t[0];
            exp_lvl.push_back(lvl);
            if (lvl && !exp_prev) exp_rise.push_back(i);
            exp_prev = lvl;
        end
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) exp_lvl.push_back(1'b0);
        exp_prev = 1'b0;
    endtask

    task automatic drive_cfg(input bit v, input int inc, input int mod);
        cfg_bus.cfg_valid = v;
        cfg_bus.cfg_inc = inc[15:0];
        cfg_bus.cfg_mod = mod[15:0];
    endtask

    // Drains the scoreboard against recorded samples and returns mismatch tallies.
    task automatic score(output int pulses, output int rise_bad, output int lvl_bad,
                         output int en_low, output int min_run, output int max_run);
        int prev_t;
        int run;
        pulses = 0; rise_bad = 0; lvl_bad = 0; en_low = 0;
        min_run = 1 << 30; max_run = 0; prev_t = -1;
        if (mon_lvl.size() != exp_lvl.size()) lvl_bad++;
        for (int i = 0; i < int'(mon_lvl.size()); i++) begin
            if (i < int'(exp_lvl.size()) && mon_lvl[i] != exp_lvl[i]) lvl_bad++;
            if (i > 0 && mon_lvl[i] != mon_lvl[i-1]) begin
                if (prev_t >= 0) begin
                    run = i - prev_t;
                    if (run < min_run) min_run = run;
                    if (run > max_run) max_run = run;
                end
                prev_t = i;
            end
            if (mon_en[i]) begin
                pulses++;
                if (!mon_lvl[i]) en_low++;
                if (exp_rise.size() == 0) rise_bad++;
                else if (exp_rise.pop_front() != i) rise_bad++;
            end
        end
        rise_bad += int'(exp_rise.size());
        if (max_run == 0) min_run = 0;
    endtask

    task automatic test_reset();
        repeat (3) step();
        n_total++; if (clk_out !== 1'b0) $display("FAIL reset_clk_out: got %b need 0", clk_out); else n_pass++;
        n_total++; if (clk_en !== 1'b0) $display("FAIL reset_clk_en: got %b need 0", clk_en); else n_pass++;
        n_total++; if (cfg_bus.cfg_err !== 1'b0) $display("FAIL reset_cfg_err: got %b need 0", cfg_bus.cfg_err); else n_pass++;
        n_total++; if (cfg_bus.cfg_ready !== 1'b1) $display("FAIL reset_cfg_ready: got %b need 1", cfg_bus.cfg_ready); else n_pass++;
        reset_n = 1'b1;
        step(); step();
        n_total++; if (clk_out !== 1'b0) $display("FAIL idle_clk_out: got %b need 0", clk_out); else n_pass++;
    endtask

    task automatic test_default_rate();
        int pulses, rise_bad, lvl_bad, en_low, min_run, max_run;
        step();
        start_record(); en = 1'b1;
        repeat (4000) step();
        stop_record();
        predict(1007, 4000, 0, 1'b0, 0, 4000);
        score(pulses, rise_bad, lvl_bad, en_low, min_run, max_run);
        n_total++; if (pulses !== 1007) $display("FAIL def_pulses: got %0d need 1007", pulses); else n_pass++;
        n_total++; if (rise_bad !== 0) $display("FAIL def_rise_times: got %0d bad need 0", rise_bad); else n_pass++;
        n_total++; if (lvl_bad !== 0) $display("FAIL def_levels: got %0d bad need 0", lvl_bad); else n_pass++;
        n_total++; if (en_low !== 0) $display("FAIL def_en_while_low: got %0d need 0", en_low); else n_pass++;
        n_total++; if (min_run < 1 || max_run > 2) $display("FAIL def_phase_len: got %0d..%0d need 1..2", min_run, max_run); else n_pass++;
    endtask

    task automatic test_apply_cfg();
        int pulses, rise_bad, lvl_bad, en_low, min_run, max_run;
        step(); en = 1'b0; step();
        n_total++; if (clk_out !== 1'b0) $display("FAIL apply_en_off_out: got %b need 0", clk_out); else n_pass++;
        n_total++; if (cfg_bus.cfg_ready !== 1'b1) $display("FAIL apply_ready_before: got %b need 1", cfg_bus.cfg_ready); else n_pass++;
        drive_cfg(1'b1, 1, 4);
        step();
        drive_cfg(1'b0, 0, 0);
        n_total++; if (cfg_bus.cfg_ready !== 1'b0) $display("FAIL apply_ready_pending: got %b need 0", cfg_bus.cfg_ready); else n_pass++;
        n_total++; if (cfg_bus.cfg_err !== 1'b0) $display("FAIL apply_no_err: got %b need 0", cfg_bus.cfg_err); else n_pass++;
        step();
        n_total++; if (cfg_bus.cfg_ready !== 1'b1) $display("FAIL apply_ready_after: got %b need 1", cfg_bus.cfg_ready); else n_pass++;
        start_record(); en = 1'b1;
        repeat (40) step();
        stop_record();
        predict(1, 4, 0, 1'b0, 0, 40);
        score(pulses, rise_bad, lvl_bad, en_low, min_run, max_run);
        n_total++; if (pulses !== 10) $display("FAIL div4_pulses: got %0d need 10", pulses); else n_pass++;
        n_total++; if (rise_bad !== 0) $display("FAIL div4_rise_times: got %0d bad need 0", rise_bad); else n_pass++;
        n_total++; if (lvl_bad !== 0) $display("FAIL div4_levels: got %0d bad need 0", lvl_bad); else n_pass++;
        n_total++; if (min_run !== 2 || max_run !== 2) $display("FAIL div4_phase_len: got %0d..%0d need 2..2", min_run, max_run); else n_pass++;
    endtask

    task automatic test_cfg_err();
        int pulses, rise_bad, lvl_bad, en_low, min_run, max_run;
        step(); en = 1'b0; step();
        start_record(); en = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (i == 5) drive_cfg(1'b1, 0, 4);
            if (i == 6 || i == 11) begin
                n_total++; if (cfg_bus.cfg_err !== 1'b1) $display("FAIL err_pulse_%0d: got %b need 1", i, cfg_bus.cfg_err); else n_pass++;
                n_total++; if (cfg_bus.cfg_ready !== 1'b1) $display("FAIL err_ready_%0d: got %b need 1", i, cfg_bus.cfg_ready); else n_pass++;
                drive_cfg(1'b0, 0, 0);
            end
            if (i == 7 || i == 12) begin
                n_total++; if (cfg_bus.cfg_err !== 1'b0) $display("FAIL err_one_cycle_%0d: got %b need 0", i, cfg_bus.cfg_err); else n_pass++;
            end
            if (i == 10) drive_cfg(1'b1, 3, 5);
        end
        stop_record();
        predict(1, 4, 0, 1'b0, 0, 40);
        score(pulses, rise_bad, lvl_bad, en_low, min_run, max_run);
        n_total++; if (rise_bad !== 0) $display("FAIL err_rise_times: got %0d bad need 0", rise_bad); else n_pass++;
        n_total++; if (lvl_bad !== 0) $display("FAIL err_levels: got %0d bad need 0", lvl_bad); else n_pass++;
    endtask

    task automatic test_midperiod_switch();
        int pulses, rise_bad, lvl_bad, en_low, min_run, max_run, exp_n;
        step(); en = 1'b0; step();
        start_record(); en = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            step();
            case (i)
                3:  drive_cfg(1'b1, 1, 8);
                13: drive_cfg(1'b1, 1, 4);
                default: ;
            endcase
            if (i == 4 || i == 14) drive_cfg(1'b0, 0, 0);
            if (i == 4 || i == 5 || i == 14 || i == 21) begin
                n_total++; if (cfg_bus.cfg_ready !== 1'b0) $display("FAIL sw_ready_wait_%0d: got %b need 0", i, cfg_bus.cfg_ready); else n_pass++;
            end
            if (i == 6 || i == 22) begin
                n_total++; if (cfg_bus.cfg_ready !== 1'b1) $display("FAIL sw_ready_back_%0d: got %b need 1", i, cfg_bus.cfg_ready); else n_pass++;
            end
        end
        stop_record();
        predict(1, 4, 0, 1'b0, 0, 5);
        predict(1, 8, 6, 1'b1, 6, 21);
        predict(1, 4, 22, 1'b1, 22, 60);
        exp_n = int'(exp_rise.size());
        score(pulses, rise_bad, lvl_bad, en_low, min_run, max_run);
        n_total++; if (pulses !== exp_n) $display("FAIL sw_pulses: got %0d need %0d", pulses, exp_n); else n_pass++;
        n_total++; if (rise_bad !== 0) $display("FAIL sw_rise_times: got %0d bad need 0", rise_bad); else n_pass++;
        n_total++; if (lvl_bad !== 0) $display("FAIL sw_levels: got %0d bad need 0", lvl_bad); else n_pass++;
        n_total++; if (min_run < 2) $display("FAIL sw_runt: got min phase %0d need >=2", min_run); else n_pass++;
    endtask

    task automatic test_en_drop();
        int pulses, rise_bad, lvl_bad, en_low, min_run, max_run;
        step(); en = 1'b0; step();
        start_record(); en = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (i == 2) begin
                n_total++; if (clk_out !== 1'b1) $display("FAIL endrop_high_before: got %b need 1", clk_out); else n_pass++;
                en = 1'b0;
            end
            if (i == 3) begin
                n_total++; if (clk_out !== 1'b0) $display("FAIL endrop_out_low: got %b need 0", clk_out); else n_pass++;
            end
            if (i == 5) en = 1'b1;
            if (i == 7) begin
                n_total++; if (clk_en !== 1'b1) $display("FAIL endrop_first_tick: got %b need 1", clk_en); else n_pass++;
            end
        end
        stop_record();
        predict(1, 4, 0, 1'b0, 0, 2);
        push_idle(3);
        predict(1, 4, 5, 1'b0, 6, 30);
        score(pulses, rise_bad, lvl_bad, en_low, min_run, max_run);
        n_total++; if (rise_bad !== 0) $display("FAIL endrop_rise_times: got %0d bad need 0", rise_bad); else n_pass++;
        n_total++; if (lvl_bad !== 0) $display("FAIL endrop_levels: got %0d bad need 0", lvl_bad); else n_pass++;
        n_total++; if (en_low !== 0) $display("FAIL endrop_en_while_low: got %0d need 0", en_low); else n_pass++;
    endtask

    task automatic test_async_reset();
        int pulses, rise_bad, lvl_bad, en_low, min_run, max_run;
        bit found;
        found = 1'b0;
        step();
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (clk_en) found = 1'b1;
        end
        n_total++; if (!found) $display("FAIL arst_wait_rise: got no clk_en in 20 cycles need one"); else n_pass++;
        drive_cfg(1'b1, 1, 8);
        step();
        drive_cfg(1'b0, 0, 0);
        n_total++; if (cfg_bus.cfg_ready !== 1'b0) $display("FAIL arst_pending: got %b need 0", cfg_bus.cfg_ready); else n_pass++;
        n_total++; if (clk_out !== 1'b1) $display("FAIL arst_high_before: got %b need 1", clk_out); else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_total++; if (clk_out !== 1'b0) $display("FAIL arst_clk_out: got %b need 0", clk_out); else n_pass++;
        n_total++; if (cfg_bus.cfg_ready !== 1'b1) $display("FAIL arst_ready: got %b need 1", cfg_bus.cfg_ready); else n_pass++;
        n_total++; if (clk_en !== 1'b0) $display("FAIL arst_clk_en: got %b need 0", clk_en); else n_pass++;
        en = 1'b0;
        step(); step();
        reset_n = 1'b1;
        step();
        start_record(); en = 1'b1;
        repeat (400) step();
        stop_record();
        predict(1007, 4000, 0, 1'b0, 0, 400);
        score(pulses, rise_bad, lvl_bad, en_low, min_run, max_run);
        n_total++; if (pulses !== 101) $display("FAIL arst_pulses: got %0d need 101", pulses); else n_pass++;
        n_total++; if (rise_bad !== 0) $display("FAIL arst_rise_times: got %0d bad need 0", rise_bad); else n_pass++;
        n_total++; if (lvl_bad !== 0) $display("FAIL arst_levels: got %0d bad need 0", lvl_bad); else n_pass++;
    endtask

    initial begin
        drive_cfg(1'b0, 0, 0);
        test_reset();
        test_default_rate();
        test_apply_cfg();
        test_cfg_err();
        test_midperiod_switch();
        test_en_drop();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/frac_clk_divider.md
FRAC_CLK_DIVIDER -- requirements
Module: frac_clk_divider

Interface
REQ-001 SHALL have parameter ACC_W, default 16, meaning the width of the increment, modulus and accumulator fields.
REQ-002 SHALL have parameter DEF_INC, default 1007, meaning the increment loaded at reset.
REQ-003 SHALL have parameter DEF_MOD, default 4000, meaning the modulus loaded at reset (1007/4000 × 100 MHz = 25.175 MHz).
REQ-004 SHALL have port clk_100MHz, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port en, input, 1 bit: run enable.
REQ-007 SHALL have port cfg_valid, input, 1 bit: a new configuration is offered.
REQ-008 SHALL have port cfg_inc, input, ACC_W bits: the offered increment.
REQ-009 SHALL have port cfg_mod, input, ACC_W bits: the offered modulus.
REQ-010 SHALL have port cfg_ready, output, 1 bit: the block can accept a configuration.
REQ-011 SHALL have port cfg_err, output, 1 bit: one-cycle pulse when an accepted configuration is rejected.
REQ-012 SHALL have port clk_out, output, 1 bit: the divided clock, registered.
REQ-013 SHALL have port clk_en, output, 1 bit: one-cycle pulse in the first cycle clk_out reads 1.

Function
REQ-014 SHALL hold active registers inc/mod and an internal accumulator acc of ACC_W+1 bits, so that sums never overflow.
REQ-015 SHALL, each cycle with en=1, compute sum = acc + 2·inc; if sum ≥ mod, assert an internal tick and load acc ← sum − mod, else load acc ← sum.
REQ-016 SHALL toggle clk_out on the clock edge that registers a tick, giving f_out = f_clk·inc/mod with half-periods differing by at most one cycle.
REQ-017 SHALL assert clk_en for exactly one cycle, coincident with each 0→1 transition of clk_out; clk_en SHALL never be asserted with clk_out=0.
REQ-018 SHALL, while en=0, clear acc to 0, drive clk_out=0 from the next cycle, and hold clk_en=0.
REQ-019 SHALL, after en returns to 1, restart from acc=0, with the first tick following REQ-015.
REQ-020 SHALL accept a configuration when cfg_valid=1 and cfg_ready=1 in the same cycle.
REQ-021 SHALL treat an accepted configuration as valid iff cfg_inc ≠ 0, cfg_mod ≠ 0 and 2·cfg_inc ≤ cfg_mod.
REQ-022 SHALL, for an invalid accepted configuration, pulse cfg_err for one cycle on the next cycle, discard the configuration, and leave cfg_ready=1.
REQ-023 SHALL, for a valid accepted configuration, latch it as pending and deassert cfg_ready from the next cycle until it is applied.
REQ-024 SHALL apply a pending configuration on the edge where clk_out goes 0→1, or on the next edge if en=0: load inc/mod, clear acc to 0, and reassert cfg_ready the following cycle.
REQ-025 SHALL NOT apply a configuration accepted in the same cycle as a rising tick at that tick; it waits for the next rising tick (glitch-free, period-boundary switching).
REQ-026 SHALL ignore cfg_valid while cfg_ready=0; no error is signalled.
REQ-027 SHALL keep clk_out free of pulses shorter than one clk_100MHz cycle under all configuration and en sequences.

Reset
REQ-028 SHALL, while reset_n=0 (asynchronous assertion), hold acc=0, inc=DEF_INC, mod=DEF_MOD, pending cleared, clk_out=0, clk_en=0, cfg_err=0, cfg_ready=1.
REQ-029 SHALL, on reset_n assertion mid-period or with a pending configuration, drop the pending configuration and restart from the defaults after release.
REQ-030 SHALL require, at elaboration, DEF_INC ≠ 0, 2·DEF_INC ≤ DEF_MOD and DEF_MOD < 2^ACC_W.

Verification
REQ-031 SHALL cover: defaults, en=1 for 4000 cycles → exactly 1007 clk_en pulses, every high/low phase lasting 1 or 2 cycles.
REQ-032 SHALL cover: configuration inc=1, mod=4 applied → clk_out period 4 cycles (2 high, 2 low), clk_en every 4th cycle.
REQ-033 SHALL cover: cfg inc=0 or inc=3/mod=5 offered → cfg_err one-cycle pulse, output unchanged, cfg_ready stays 1.
REQ-034 SHALL cover: cfg inc=1/mod=8 accepted mid-period → cfg_ready=0 until the next 0→1 of clk_out, new 8-cycle period starting exactly there, no runt pulse.
REQ-035 SHALL cover: en dropped mid-high-phase → clk_out=0 next cycle; en raised again → first tick after the cycle count set by REQ-015 from acc=0.
REQ-036 SHALL cover: reset_n pulsed low asynchronously with a configuration pending → immediate clk_out=0, cfg_ready=1, and the default 1007/4000 rate resumes after release.
